rename_sequencer: RTL
=====================

// Module: rename_sequencer
// PURPOSE
//  Controls the rename map table (32 entries, tag 0 = "value in register file"). Allocates ROB tags in order,
//  issues decode-side map writes, generates per-register commit clears when the committing tag still owns
//  its register, and runs a flush sequence that clears the whole table after a misprediction.
//  Sits between decode, the ROB commit stage and the map table.
// PARAMETERS
//  ROBsize   16                      number of ROB entries; valid tags are 1..ROBsize
//  tagW      $clog2(ROBsize+1)       tag width; equals map table value width
// PORTS
//  clk                  in   1     clock, rising edge
//  reset                in   1     reset, synchronous, active-high
//  dec_valid_i          in   1     decode has an instruction to rename
//  dec_regWrite_i       in   1     instruction writes a destination register
//  dec_rd_i             in   5     destination register
//  dec_ready_o          out  1     rename accepts this cycle
//  dec_tag_o            out  tagW  ROB tag assigned to the accepted instruction (= tail)
//  commit_valid_i       in   1     ROB head is retiring
//  commit_regWrite_i    in   1     retiring instruction wrote a register
//  commit_rd_i          in   5     its destination register
//  commit_ready_o       out  1     commit accepted this cycle
//  flush_i              in   1     misprediction flush request
//  mt_writeAddr_o       out  5     map table decode write address (= dec_rd_i)
//  mt_writeData_o       out  tagW  map table decode write data (= tail)
//  mt_regWrite_o        out  1     map table decode write enable
//  mt_commitReadAddr_o  out  5     map table commit read address (= commit_rd_i)
//  mt_commitReadData_i  in   tagW  map table commit read data
//  mt_resets_o          out  32    per-entry clear to map table (one-hot or zero)
//  mt_reset_o           out  1     whole-table clear to map table
//  rob_count_o          out  tagW  in-flight tag count, 0..ROBsize
// BEHAVIOUR
//  State: INIT, RUN, FLUSH. reset (any cycle, incl. mid-flush) -> INIT, head=1, tail=1, count=0.
//  INIT: mt_reset_o=1, both readys 0; next RUN. FLUSH: mt_reset_o=1, readys 0, head=tail=1, count=0; next RUN.
//  RUN: mt_reset_o=0. flush_i in RUN -> FLUSH next cycle; in that cycle both readys forced 0 (nothing fires).
//  flush_i in INIT/FLUSH ignored (table is already being cleared).
//  dec_ready_o = RUN & ~flush_i & (count < ROBsize). dec fire = dec_valid_i & dec_ready_o.
//  commit_ready_o = RUN & ~flush_i & (count > 0). commit fire = commit_valid_i & commit_ready_o.
//  Register 31 is the zero register: never written, never cleared.
//  mt_regWrite_o = dec fire & dec_regWrite_i & (dec_rd_i != 31), combinational, same cycle.
//  mt_resets_o[commit_rd_i] = commit fire & commit_regWrite_i & (commit_rd_i != 31)
//    & (mt_commitReadData_i == head); all other bits 0. Combinational, same cycle.
//  Same-cycle decode write to the committing register: clear still driven; map table gives the write priority.
//  dec fire: tail <= tail==ROBsize ? 1 : tail+1. commit fire: head <= head==ROBsize ? 1 : head+1.
//  count <= count + dec fire - commit fire (both fire: unchanged). Full: count==ROBsize, dec_ready_o=0,
//    commit still allowed. Empty: count==0, commit_ready_o=0, decode still allowed.
//  Tag 0 is never issued. Registered state: state, head, tail, count; all other outputs combinational.
//  Outputs during reset cycle and INIT: readys 0, mt_regWrite_o 0, mt_resets_o 0, mt_reset_o 1 (INIT), count 0.
// TESTING
//  1 reset, then idle: INIT cycle shows mt_reset_o=1; next cycle RUN, dec_ready_o=1, commit_ready_o=0, dec_tag_o=1.
//  2 rename rd=5,6,7 (regWrite=1) over 3 cycles -> mt_writeData_o 1,2,3, mt_regWrite_o=1 each, rob_count_o=3;
//    rd=31 -> tag consumed, mt_regWrite_o=0.
//  3 commit rd=5 with mt_commitReadData_i=1 (head=1) -> mt_resets_o=32'h20; repeat with read data 4 -> mt_resets_o=0.
//  4 ROBsize=16: 16 renames -> dec_ready_o=0, count=16; rename+commit same cycle after one commit -> count held,
//    tail wraps 16->1, next dec_tag_o=1.
//  5 flush_i with count=5 and dec_valid_i=1 -> no fire that cycle; next cycle mt_reset_o=1, count=0;
//    following cycle RUN, dec_tag_o=1.
//  6 reset asserted during FLUSH -> INIT next cycle, head=tail=1, then RUN; commit rd=6 while decode writes rd=6
//    -> mt_resets_o bit 6 and mt_regWrite_o both high.

Source files
------------

// File: rtl/rename_sequencer.sv
// rename_sequencer: in-order ROB tag allocation and rename map table control.
// Decode-side map writes, commit-side per-register clears when the retiring
// tag still owns its register, and a whole-table clear after a flush.
module rename_sequencer #(
  parameter int ROBsize = 16,
  parameter int tagW    = $clog2(ROBsize+1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dec_valid_i,
  input  logic            dec_regWrite_i,
  input  logic [4:0]      dec_rd_i,
  output logic            dec_ready_o,
  output logic [tagW-1:0] dec_tag_o,
  input  logic            commit_valid_i,
  input  logic            commit_regWrite_i,
  input  logic [4:0]      commit_rd_i,
  output logic            commit_ready_o,
  input  logic            flush_i,
  output logic [4:0]      mt_writeAddr_o,
  output logic [tagW-1:0] mt_writeData_o,
  output logic            mt_regWrite_o,
  output logic [4:0]      mt_commitReadAddr_o,
  input  logic [tagW-1:0] mt_commitReadData_i,
  output logic [31:0]     mt_resets_o,
  output logic            mt_reset_o,
  output logic [tagW-1:0] rob_count_o
);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [tagW-1:0] TAG_MAX = tagW'(ROBsize);
  localparam logic [tagW-1:0] TAG_ONE = tagW'(1);
  localparam logic [4:0]      REG_ZERO = 5'd31;

  logic [1:0]      state_q, state_d;
  logic [tagW-1:0] head_q, head_d;
  logic [tagW-1:0] tail_q, tail_d;
  logic [tagW-1:0] count_q, count_d;

  logic run, dec_fire, com_fire, com_clr;

  // Handshakes are only open in RUN, outside reset, and never in the flush request cycle.
  always_comb begin
    run            = (state_q == S_RUN) & ~reset;
    dec_ready_o    = run & ~flush_i & (count_q < TAG_MAX);
    commit_ready_o = run & ~flush_i & (count_q != '0);
    dec_fire       = dec_valid_i & dec_ready_o;
    com_fire       = commit_valid_i & commit_ready_o;
    com_clr        = com_fire & commit_regWrite_i & (commit_rd_i != REG_ZERO)
                     & (mt_commitReadData_i == head_q);
  end

  // Map table drive: decode write, commit clear (write wins inside the table), full clear.
  always_comb begin
    dec_tag_o           = tail_q;
    mt_writeAddr_o      = dec_rd_i;
    mt_writeData_o      = tail_q;
    mt_regWrite_o       = dec_fire & dec_regWrite_i & (dec_rd_i != REG_ZERO);
    mt_commitReadAddr_o = commit_rd_i;
    mt_resets_o         = com_clr ? (32'd1 << commit_rd_i) : 32'd0;
    mt_reset_o          = reset | (state_q != S_RUN);
    rob_count_o         = reset ? '0 : count_q;
  end

  // Next-state: pointer advance with wrap, count tracking, flush sequencing.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (state_q)
      S_INIT: state_d = S_RUN;
      S_FLUSH: begin
        state_d = S_RUN;
        head_d  = TAG_ONE;
        tail_d  = TAG_ONE;
        count_d = '0;
      end
      S_RUN: begin
        if (flush_i) begin
          state_d = S_FLUSH;
          head_d  = TAG_ONE;
          tail_d  = TAG_ONE;
          count_d = '0;
        end else begin
          if (dec_fire) tail_d = (tail_q == TAG_MAX) ? TAG_ONE : tail_q + TAG_ONE;
          if (com_fire) head_d = (head_q == TAG_MAX) ? TAG_ONE : head_q + TAG_ONE;
          case ({dec_fire, com_fire})
            2'b10:   count_d = count_q + TAG_ONE;
            2'b01:   count_d = count_q - TAG_ONE;
            default: count_d = count_q;
          endcase
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // State registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      head_q  <= TAG_ONE;
      tail_q  <= TAG_ONE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
